// File: rtl/enc_8b10b_lanes_if.sv
// Bus interface for enc_8b10b_lanes: byte/K inputs and 10b code outputs.
// With ENC_KERR_EN defined the per-lane illegal-K flag out_kerr is present.
interface enc_8b10b_lanes_if #(
  parameter int LANES = 1
);
  logic                  in_valid;
  logic [8*LANES-1:0]    in_data;
  logic [LANES-1:0]      in_k;
  logic                  out_valid;
  logic [10*LANES-1:0]   out_code;
  logic                  out_rd;
`ifdef ENC_KERR_EN
  logic [LANES-1:0]      out_kerr;

  modport master (output in_valid, in_data, in_k,
                  input  out_valid, out_code, out_rd, out_kerr);
  modport slave  (input  in_valid, in_data, in_k,
                  output out_valid, out_code, out_rd, out_kerr);
`else
  modport master (output in_valid, in_data, in_k,
                  input  out_valid, out_code, out_rd);
  modport slave  (input  in_valid, in_data, in_k,
                  output out_valid, out_code, out_rd);
`endif
endinterface

// File: rtl/enc_8b10b_lanes.sv
// Multi-lane 8b/10b encoder: input register, sub-block classification register,
// then code selection with lane-chained running disparity. Optional ENC_KERR_EN.
module enc_8b10b_lanes #(
  parameter int LANES   = 1,
  parameter bit INIT_RD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  enc_8b10b_lanes_if.slave bus
);

  // RD-independent description of one byte; code6/code4 are the RD- forms
  typedef struct packed {
    logic [5:0] code6;
    logic       flip6;
    logic       sel6;
    logic [3:0] code4;
    logic       flip4;
    logic       sel4;
    logic       a7k;
    logic       a7m;
    logic       a7p;
    logic       k28b;
  } cls_t;

  function automatic logic [5:0] code6_rdm(input logic [4:0] x);
    case (x)
      5'd0:    code6_rdm = 6'b100111;
      5'd1:    code6_rdm = 6'b011101;
      5'd2:    code6_rdm = 6'b101101;
      5'd3:    code6_rdm = 6'b110001;
      5'd4:    code6_rdm = 6'b110101;
      5'd5:    code6_rdm = 6'b101001;
      5'd6:    code6_rdm = 6'b011001;
      5'd7:    code6_rdm = 6'b111000;
      5'd8:    code6_rdm = 6'b111001;
      5'd9:    code6_rdm = 6'b100101;
      5'd10:   code6_rdm = 6'b010101;
      5'd11:   code6_rdm = 6'b110100;
      5'd12:   code6_rdm = 6'b001101;
      5'd13:   code6_rdm = 6'b101100;
      5'd14:   code6_rdm = 6'b011100;
      5'd15:   code6_rdm = 6'b010111;
      5'd16:   code6_rdm = 6'b011011;
      5'd17:   code6_rdm = 6'b100011;
      5'd18:   code6_rdm = 6'b010011;
      5'd19:   code6_rdm = 6'b110010;
      5'd20:   code6_rdm = 6'b001011;
      5'd21:   code6_rdm = 6'b101010;
      5'd22:   code6_rdm = 6'b011010;
      5'd23:   code6_rdm = 6'b111010;
      5'd24:   code6_rdm = 6'b110011;
      5'd25:   code6_rdm = 6'b100110;
      5'd26:   code6_rdm = 6'b010110;
      5'd27:   code6_rdm = 6'b110110;
      5'd28:   code6_rdm = 6'b001110;
      5'd29:   code6_rdm = 6'b101110;
      5'd30:   code6_rdm = 6'b011110;
      5'd31:   code6_rdm = 6'b101011;
      default: code6_rdm = 6'b000000;
    endcase
  endfunction

  function automatic logic [3:0] code4_rdm(input logic [2:0] y);
    case (y)
      3'd0:    code4_rdm = 4'b1011;
      3'd1:    code4_rdm = 4'b1001;
      3'd2:    code4_rdm = 4'b0101;
      3'd3:    code4_rdm = 4'b1100;
      3'd4:    code4_rdm = 4'b1101;
      3'd5:    code4_rdm = 4'b1010;
      3'd6:    code4_rdm = 4'b0110;
      3'd7:    code4_rdm = 4'b1110;
      default: code4_rdm = 4'b0000;
    endcase
  endfunction

  // Ones count other than three means the 6b sub-block is unbalanced
  function automatic logic unbal6(input logic [5:0] c);
    logic [2:0] ones;
    ones = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} +
           {2'b00, c[3]} + {2'b00, c[4]} + {2'b00, c[5]};
    unbal6 = (ones != 3'd3);
  endfunction

  function automatic logic k_valid(input logic [7:0] d);
    k_valid = (d[4:0] == 5'd28) ||
              ((d[7:5] == 3'd7) && ((d[4:0] == 5'd23) || (d[4:0] == 5'd27) ||
                                    (d[4:0] == 5'd29) || (d[4:0] == 5'd30)));
  endfunction

  // Illegal K bytes fall through to the D-character classification
  function automatic cls_t classify(input logic [7:0] d, input logic k);
    cls_t       c;
    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       k28;
    x       = d[4:0];
    y       = d[7:5];
    k_ok    = k && k_valid(d);
    k28     = k_ok && (x == 5'd28);
    c.code6 = k28 ? 6'b001111 : code6_rdm(x);
    c.flip6 = unbal6(c.code6);
    c.sel6  = !k28 && (x == 5'd7);
    c.code4 = code4_rdm(y);
    c.flip4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
    c.sel4  = (y == 3'd3);
    c.a7k   = k_ok && (y == 3'd7);
    c.a7m   = !k_ok && (y == 3'd7) && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
    c.a7p   = !k_ok && (y == 3'd7) && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14));
    c.k28b  = k28 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6));
    return c;
  endfunction

  logic                    in_valid_r;
  logic [8*LANES-1:0]      in_data_r;
  logic [LANES-1:0]        in_k_r;
  logic                    s1_valid_r;
  cls_t [LANES-1:0]        cls_s;
  cls_t [LANES-1:0]        s1_cls_r;
  logic [10*LANES-1:0]     code_s;
  logic                    rd_end_s;
  logic                    rd_r;
  logic                    out_valid_r;
  logic [10*LANES-1:0]     out_code_r;

  // Input capture register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_r <= 1'b0;
      in_data_r  <= '0;
      in_k_r     <= '0;
    end else begin
      in_valid_r <= bus.in_valid;
      in_data_r  <= bus.in_data;
      in_k_r     <= bus.in_k;
    end
  end

  // Per-lane sub-block classification
  always_comb begin
    cls_s = '0;
    for (int n = 0; n < LANES; n++) begin
      cls_s[n] = classify(in_data_r[8*n +: 8], in_k_r[n]);
    end
  end

  // Classification register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_cls_r   <= '0;
    end else begin
      s1_valid_r <= in_valid_r;
      s1_cls_r   <= cls_s;
    end
  end

  // Code selection with RD chained lane 0 -> lane LANES-1
  always_comb begin
    logic       rd_v;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       a7;
    rd_v   = rd_r;
    c6     = 6'b000000;
    c4     = 4'b0000;
    a7     = 1'b0;
    code_s = '0;
    for (int n = 0; n < LANES; n++) begin
      if ((s1_cls_r[n].flip6 || s1_cls_r[n].sel6) && rd_v) begin
        c6 = ~s1_cls_r[n].code6;
      end else begin
        c6 = s1_cls_r[n].code6;
      end
      rd_v = rd_v ^ s1_cls_r[n].flip6;
      a7 = s1_cls_r[n].a7k || (s1_cls_r[n].a7m && !rd_v) || (s1_cls_r[n].a7p && rd_v);
      c4 = a7 ? 4'b0111 : s1_cls_r[n].code4;
      // K28.y balanced 4b codes track the 6b complement rather than staying fixed
      if ((s1_cls_r[n].flip4 || s1_cls_r[n].sel4) && rd_v) begin
        c4 = ~c4;
      end else if (s1_cls_r[n].k28b && !rd_v) begin
        c4 = ~c4;
      end else begin
        c4 = c4;
      end
      rd_v = rd_v ^ s1_cls_r[n].flip4;
      code_s[10*n +: 10] = {c6, c4};
    end
    rd_end_s = rd_v;
  end

  // Output and RD register; code and RD hold across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_code_r  <= '0;
      rd_r        <= INIT_RD;
    end else if (s1_valid_r) begin
      out_valid_r <= 1'b1;
      out_code_r  <= code_s;
      rd_r        <= rd_end_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_code  = out_code_r;
  assign bus.out_rd    = rd_r;

`ifdef ENC_KERR_EN
  logic [LANES-1:0] kerr_s;
  logic [LANES-1:0] s1_kerr_r;
  logic [LANES-1:0] out_kerr_r;

  // Illegal-K detection on the captured input
  always_comb begin
    kerr_s = '0;
    for (int n = 0; n < LANES; n++) begin
      kerr_s[n] = in_k_r[n] && !k_valid(in_data_r[8*n +: 8]);
    end
  end

  // Illegal-K flag pipeline, cleared on bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_kerr_r  <= '0;
      out_kerr_r <= '0;
    end else begin
      s1_kerr_r  <= kerr_s;
      out_kerr_r <= s1_valid_r ? s1_kerr_r : '0;
    end
  end

  assign bus.out_kerr = out_kerr_r;
`endif

endmodule

// File: tb/tb_enc_8b10b_lanes.sv
// Scoreboard bench for enc_8b10b_lanes: three instances (1 lane RD-, 2 lanes RD-,
// 1 lane RD+) driven with hand-computed vectors; monitors check at negedge.
module tb_enc_8b10b_lanes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] code;
    logic        rd;
    logic [1:0]  kerr;
    int          due;
  } exp_t;

  exp_t        q [3][$];
  logic [19:0] hold_code [3];
  logic        hold_rd   [3];

  enc_8b10b_lanes_if #(.LANES(1)) ia ();
  enc_8b10b_lanes_if #(.LANES(2)) ib ();
  enc_8b10b_lanes_if #(.LANES(1)) ic ();

  enc_8b10b_lanes #(.LANES(1), .INIT_RD(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  enc_8b10b_lanes #(.LANES(2), .INIT_RD(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  enc_8b10b_lanes #(.LANES(1), .INIT_RD(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [19:0] code,
                     input logic rd, input logic [1:0] kerr, input logic r);
    exp_t  e;
    string tag;
    tag = $sformatf("dut%0d", d);
    if (v === 1'b1) begin
      if (q[d].size() == 0) begin
        chk({tag, ".unexpected_valid"}, 32'(v), 32'd0);
      end else begin
        e = q[d].pop_front();
        chk({tag, ".latency"}, 32'(cyc), 32'(e.due));
        chk({tag, ".code"}, 32'(code), 32'(e.code));
        chk({tag, ".rd"}, 32'(rd), 32'(e.rd));
`ifdef ENC_KERR_EN
        chk({tag, ".kerr"}, 32'(kerr), 32'(e.kerr));
`endif
        hold_code[d] = e.code;
        hold_rd[d]   = e.rd;
      end
    end else begin
      chk({tag, ".hold_code"}, 32'(code), 32'(hold_code[d]));
      chk({tag, ".hold_rd"}, 32'(rd), 32'(hold_rd[d]));
`ifdef ENC_KERR_EN
      chk({tag, ".idle_kerr"}, 32'(kerr), 32'd0);
`endif
      if (q[d].size() != 0 && q[d][0].due <= cyc) begin
        void'(q[d].pop_front());
        chk({tag, ".out_valid"}, 32'(v), 32'd1);
      end
    end
    if (r) begin
      q[d].delete();
      hold_code[d] = 20'h00000;
      hold_rd[d]   = (d == 2);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
`ifdef ENC_KERR_EN
    mon(0, ia.out_valid, 20'(ia.out_code), ia.out_rd, {1'b0, ia.out_kerr}, rst);
    mon(1, ib.out_valid, ib.out_code, ib.out_rd, ib.out_kerr, rst);
    mon(2, ic.out_valid, 20'(ic.out_code), ic.out_rd, {1'b0, ic.out_kerr}, rst);
`else
    mon(0, ia.out_valid, 20'(ia.out_code), ia.out_rd, 2'b00, rst);
    mon(1, ib.out_valid, ib.out_code, ib.out_rd, 2'b00, rst);
    mon(2, ic.out_valid, 20'(ic.out_code), ic.out_rd, 2'b00, rst);
`endif
  end

  task automatic idle_all();
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    ic.in_valid = 1'b0;
  endtask

  task automatic drive(input int d, input logic v, input logic [15:0] data, input logic [1:0] k,
                       input logic [19:0] ec, input logic erd, input logic [1:0] ek);
    exp_t e;
    @(posedge clk);
    #1;
    idle_all();
    case (d)
      0: begin ia.in_valid = v; ia.in_data = data[7:0]; ia.in_k = k[0]; end
      1: begin ib.in_valid = v; ib.in_data = data;      ib.in_k = k;    end
      default: begin ic.in_valid = v; ic.in_data = data[7:0]; ic.in_k = k[0]; end
    endcase
    if (v) begin
      e.code = ec;
      e.rd   = erd;
      e.kerr = ek;
      e.due  = cyc + 3;
      q[d].push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    idle_all();
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      hold_code[d] = 20'h00000;
      hold_rd[d]   = (d == 2);
    end
    idle_all();
    ia.in_data = 8'h00;  ia.in_k = 1'b0;
    ib.in_data = 16'h0000; ib.in_k = 2'b00;
    ic.in_data = 8'h00;  ic.in_k = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.a.valid", 32'(ia.out_valid), 32'd0);
    chk("reset.a.code", 32'(ia.out_code), 32'd0);
    chk("reset.a.rd", 32'(ia.out_rd), 32'd0);
    chk("reset.b.valid", 32'(ib.out_valid), 32'd0);
    chk("reset.b.code", 32'(ib.out_code), 32'd0);
    chk("reset.c.rd", 32'(ic.out_rd), 32'd1);

    // Single lane, RD- start
    drive(0, 1'b1, 16'h0000, 2'b00, 20'h274, 1'b0, 2'b00);  // D.0.0
    drive(0, 1'b1, 16'h00BC, 2'b01, 20'h0FA, 1'b1, 2'b00);  // K28.5 RD-
    drive(0, 1'b1, 16'h00BC, 2'b01, 20'h305, 1'b0, 2'b00);  // K28.5 RD+
    drive(0, 1'b1, 16'h00B5, 2'b00, 20'h2AA, 1'b0, 2'b00);  // D.21.5
    drive(0, 1'b1, 16'h00F1, 2'b00, 20'h237, 1'b1, 2'b00);  // D.17.7 alternate
    drive(0, 1'b0, 16'h0000, 2'b00, 20'h000, 1'b0, 2'b00);  // bubble
    drive(0, 1'b1, 16'h0000, 2'b00, 20'h18B, 1'b1, 2'b00);  // D.0.0 RD+
    drive(0, 1'b1, 16'h0000, 2'b01, 20'h18B, 1'b1, 2'b01);  // illegal K -> D.0.0
    drive(0, 1'b1, 16'h00BC, 2'b01, 20'h305, 1'b0, 2'b00);  // K28.5 RD+
    drive(0, 1'b1, 16'h0067, 2'b00, 20'h38C, 1'b0, 2'b00);  // D.7.3 RD-
    drive(0, 1'b1, 16'h00EB, 2'b00, 20'h34E, 1'b1, 2'b00);  // D.11.7 RD- primary
    drive(0, 1'b1, 16'h00EB, 2'b00, 20'h348, 1'b0, 2'b00);  // D.11.7 RD+ alternate
    drive(0, 1'b1, 16'h00FC, 2'b01, 20'h0F8, 1'b0, 2'b00);  // K28.7
    drive(0, 1'b1, 16'h00F7, 2'b01, 20'h3A8, 1'b0, 2'b00);  // K23.7
    drive(0, 1'b1, 16'h003C, 2'b01, 20'h0F9, 1'b1, 2'b00);  // K28.1 RD-
    drive(0, 1'b1, 16'h003C, 2'b01, 20'h306, 1'b0, 2'b00);  // K28.1 RD+

    // Two lanes, RD chained across lanes and cycles
    drive(1, 1'b1, 16'hBCBC, 2'b11, 20'hC14FA, 1'b0, 2'b00);
    drive(1, 1'b1, 16'hBCBC, 2'b11, 20'hC14FA, 1'b0, 2'b00);
    drive(1, 1'b1, 16'hBCBC, 2'b11, 20'hC14FA, 1'b0, 2'b00);
    drive(1, 1'b1, 16'hB500, 2'b00, 20'hAAA74, 1'b0, 2'b00);
    drive(1, 1'b1, 16'h00F1, 2'b00, 20'h62E37, 1'b1, 2'b00);
    drive(1, 1'b1, 16'hBCBC, 2'b11, 20'h3EB05, 1'b1, 2'b00);
    drive(1, 1'b1, 16'h00BC, 2'b11, 20'h9D305, 1'b0, 2'b10);

    // RD+ reset value
    drive(2, 1'b1, 16'h0000, 2'b00, 20'h18B, 1'b1, 2'b00);
    drive(2, 1'b1, 16'h00BC, 2'b01, 20'h305, 1'b0, 2'b00);

    // Mid-stream reset: two D.0.0 words are discarded and RD returns to RD-
    drive(0, 1'b1, 16'h00BC, 2'b01, 20'h0FA, 1'b1, 2'b00);
    drive(0, 1'b1, 16'h0000, 2'b00, 20'h18B, 1'b1, 2'b00);
    drive(0, 1'b1, 16'h0000, 2'b00, 20'h18B, 1'b1, 2'b00);
    do_reset(2);
    repeat (4) drive(0, 1'b0, 16'h0000, 2'b00, 20'h000, 1'b0, 2'b00);
    drive(0, 1'b1, 16'h0000, 2'b00, 20'h274, 1'b0, 2'b00);
    drive(0, 1'b0, 16'h0000, 2'b00, 20'h000, 1'b0, 2'b00);

    for (int i = 0; i < 20; i++) begin
      if (q[0].size() + q[1].size() + q[2].size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
